// File: rtl/connect4_pkg.sv
// connect4_pkg: shared Connect-4 game encodings, board size and scheduler state/auto-pick constants
package connect4_pkg;
  localparam int NUM_COLS = 7;
  localparam int NUM_ROWS = 6;
  typedef enum logic [2:0] {
    GS_IDLE     = 3'd0,
    PLAYER_TURN = 3'd1,
    GS_DROP     = 3'd2,
    GS_CHECK    = 3'd3,
    GS_OVER     = 3'd4
  } state_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_HUMAN,
`ifdef AUTO_MOVE_EN
    S_AUTO_SEEK,
    S_AUTO_DROP,
`endif
    S_WAIT_ACK
  } sched_t;
  localparam logic [3*NUM_COLS-1:0] AUTO_ORDER = {3'd6, 3'd0, 3'd5, 3'd1, 3'd4, 3'd2, 3'd3};
endpackage

// File: rtl/turn_timer.sv
// turn_timer: per-turn tick/second countdown with a one-cycle expire strobe
// Ports: clk, reset (sync, active-high), load_i (restart at TURN_SECONDS),
//        en_i (count this cycle), seconds_left_o (registered), expire_o (wrap that reaches 0)
module turn_timer #(
  parameter int CYCLES_PER_SEC = 50_000_000,
  parameter int TURN_SECONDS   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       en_i,
  output logic [3:0] seconds_left_o,
  output logic       expire_o
);
  localparam int TW = CYCLES_PER_SEC > 1 ? $clog2(CYCLES_PER_SEC) : 1;
  logic [TW-1:0] tick_q;
  logic [3:0] sec_q;
  logic wrap;
  assign wrap = tick_q == TW'(CYCLES_PER_SEC - 1);
  assign expire_o = en_i && wrap && sec_q == 4'd1;
  assign seconds_left_o = sec_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
      sec_q <= '0;
    end else if (load_i) begin
      tick_q <= '0;
      sec_q <= 4'(TURN_SECONDS);
    end else if (en_i) begin
      tick_q <= wrap ? '0 : tick_q + 1'b1;
      if (wrap && sec_q != 4'd0) sec_q <= sec_q - 1'b1;
    end
  end
endmodule

// File: rtl/connect4_turn_scheduler.sv
// connect4_turn_scheduler: gates player buttons into the game FSM, runs the turn countdown, plays a move on timeout
// Ports: clk, reset (sync, active-high), state_in (game FSM state), col_pos/col_full (selector and board),
//        btn_left/btn_right/btn_drop (button pulses) -> move_left/move_right/move_made, times_up,
//        seconds_left, auto_active (all registered).
// AUTO_MOVE_EN: defined = timeout seeks and drops automatically; undefined = times_up is held until the turn ends.
module connect4_turn_scheduler
  import connect4_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 50_000_000,
  parameter int TURN_SECONDS   = 10,
  parameter int STEP_GAP       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          state_in,
  input  logic [2:0]          col_pos,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_drop,
  output logic                move_left,
  output logic                move_right,
  output logic                move_made,
  output logic                times_up,
  output logic [3:0]          seconds_left,
  output logic                auto_active
);
  sched_t state_q;
  logic [2:0] state_in_q;
  logic move_left_q, move_right_q, move_made_q, times_up_q, auto_active_q;
  logic in_turn, entry, expire;
  assign in_turn = state_in == PLAYER_TURN;
  assign entry = in_turn && state_in_q != PLAYER_TURN;
  turn_timer #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC),
    .TURN_SECONDS  (TURN_SECONDS)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .load_i        (state_q == S_IDLE && entry),
    .en_i          (state_q == S_HUMAN && in_turn),
    .seconds_left_o(seconds_left),
    .expire_o      (expire)
  );
`ifdef AUTO_MOVE_EN
  localparam int GW = $clog2(STEP_GAP + 1);
  logic [2:0] tgt_d, tgt_q;
  logic tgt_ok_d, tgt_ok_q;
  logic [GW-1:0] gap_q;
  // Scan in reverse so the earliest non-full column in the pick order wins.
  always_comb begin
    tgt_d = '0;
    tgt_ok_d = 1'b0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!col_full[AUTO_ORDER[3*i +: 3]]) begin
        tgt_d = AUTO_ORDER[3*i +: 3];
        tgt_ok_d = 1'b1;
      end
    end
  end
`else
  localparam int unused_step_gap = STEP_GAP;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      state_in_q <= '0;
      {move_left_q, move_right_q, move_made_q, times_up_q, auto_active_q} <= '0;
`ifdef AUTO_MOVE_EN
      tgt_q <= '0;
      tgt_ok_q <= 1'b0;
      gap_q <= '0;
`endif
    end else begin
      state_in_q <= state_in;
      {move_left_q, move_right_q, move_made_q, times_up_q} <= '0;
      case (state_q)
        S_IDLE: if (entry) state_q <= S_HUMAN;
        S_HUMAN:
          if (!in_turn) state_q <= S_IDLE;
          else if (expire) begin
            times_up_q <= 1'b1;
`ifdef AUTO_MOVE_EN
            state_q <= S_AUTO_SEEK;
            auto_active_q <= 1'b1;
            tgt_q <= tgt_d;
            tgt_ok_q <= tgt_ok_d;
            gap_q <= '0;
`else
            state_q <= S_WAIT_ACK;
`endif
          end else if (btn_drop) begin
            if (!col_full[col_pos]) begin
              move_made_q <= 1'b1;
              state_q <= S_WAIT_ACK;
            end
          end else if (btn_left ^ btn_right) begin
            move_left_q <= btn_left;
            move_right_q <= btn_right;
          end
`ifdef AUTO_MOVE_EN
        S_AUTO_SEEK:
          if (!in_turn || !tgt_ok_q) begin
            state_q <= S_IDLE;
            auto_active_q <= 1'b0;
          end else if (gap_q != '0) gap_q <= gap_q - 1'b1;
          else begin
            gap_q <= GW'(STEP_GAP - 1);
            if (col_pos == tgt_q) begin
              move_made_q <= 1'b1;
              state_q <= S_AUTO_DROP;
            end else begin
              move_right_q <= col_pos < tgt_q;
              move_left_q <= col_pos > tgt_q;
            end
          end
        S_AUTO_DROP: begin
          state_q <= S_WAIT_ACK;
          auto_active_q <= 1'b0;
        end
`endif
        S_WAIT_ACK: begin
`ifndef AUTO_MOVE_EN
          times_up_q <= times_up_q && in_turn;
`endif
          if (!in_turn) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign move_left = move_left_q;
  assign move_right = move_right_q;
  assign move_made = move_made_q;
  assign times_up = times_up_q;
  assign auto_active = auto_active_q;
endmodule

// File: doc/connect4_turn_scheduler.md
# connect4_turn_scheduler

Per-turn move sequencer between the debounced player buttons and the Connect-4 game FSM. Forwards human left/right/drop requests only while the FSM waits for a move, and blocks drops into full columns. Runs the per-turn countdown and drives `times_up`. On timeout it takes over the column selector and plays an automatic move.

## Interface
- `CYCLES_PER_SEC`, default 50_000_000: clock cycles per displayed second.
- `TURN_SECONDS`, default 10: turn length in seconds, 1..15.
- `STEP_GAP`, default 2: cycles between automatic selector pulses, ≥2.
- `clk`  in  1  system clock.
- `reset`  in  1  reset. One clock; reset is synchronous and active-high.
- `state_in`  in  3  game FSM state; PLAYER_TURN = 3'd1.
- `col_pos`  in  3  current selector column, 0..6.
- `col_full`  in  7  bit c set = column c full.
- `btn_left`, `btn_right`, `btn_drop`  in  1 each  single-cycle button pulses.
- `move_left`, `move_right`, `move_made`  out  1 each  single-cycle pulses to the selector and FSM.
- `times_up`  out  1  single-cycle pulse on timeout.
- `seconds_left`  out  4  remaining seconds for display.
- `auto_active`  out  1  high while an automatic move is in progress.

## Operation
- States: IDLE, HUMAN, AUTO_SEEK, AUTO_DROP, WAIT_ACK.
- A registered copy of `state_in` detects turn entry, i.e. `state_in` becomes 1 from any other value.
- IDLE: on turn entry, go to HUMAN. Load `seconds_left`=TURN_SECONDS and clear the tick counter.
- HUMAN, button handling:
  - `btn_drop` wins over left/right.
  - A drop is forwarded only if `col_full[col_pos]`=0, then the block goes to WAIT_ACK. A drop into a full column is discarded and the block stays in HUMAN.
  - `btn_left` and `btn_right` in the same cycle are both discarded.
  - `btn_left` at col 0 and `btn_right` at col 6 are still forwarded. The selector clamps them.
- HUMAN, countdown:
  - The tick counter increments every cycle.
  - At CYCLES_PER_SEC-1 the tick counter wraps and `seconds_left` decrements.
  - The wrap that takes `seconds_left` to 0 is the timeout: pulse `times_up` and go to AUTO_SEEK.
  - A button in the timeout cycle is discarded.
- AUTO_SEEK, target selection:
  - On entry, latch the target: the first non-full column in order 3,2,4,1,5,0,6.
  - If all columns are full, do not pulse, return to IDLE and set `seconds_left`=0.
- AUTO_SEEK, stepping:
  - Buttons are ignored.
  - Issue `move_right` if `col_pos`<target, `move_left` if `col_pos`>target.
  - The first pulse comes the cycle after entry, then one pulse every STEP_GAP cycles.
  - When `col_pos`==target at a step slot, go to AUTO_DROP.
- AUTO_DROP: pulse `move_made` for one cycle, then go to WAIT_ACK.
- WAIT_ACK: all outputs idle. Return to IDLE when `state_in`≠1.
- Leaving PLAYER_TURN early: if `state_in` leaves 1 while in HUMAN or AUTO_SEEK, abort to IDLE.
- `auto_active` is high in AUTO_SEEK and AUTO_DROP.
- Reset:
  - FSM, counters and the `state_in` copy are cleared.
  - All outputs are 0: `seconds_left`=0, all pulses low, `auto_active`=0.
  - Reset mid-move discards any pending pulse.

## Timing
- All outputs are registered. A button pulse in cycle n gives the output pulse in cycle n+1.
- Timeout comes exactly TURN_SECONDS×CYCLES_PER_SEC cycles after the turn-entry cycle.
- The `times_up` pulse is coincident with AUTO_SEEK entry.
- The `col_pos` response to a pulse is expected within STEP_GAP-1 cycles.
- The `move_made` pulse comes STEP_GAP cycles after the last step pulse. If no step is needed, it comes 1 cycle after AUTO_SEEK entry.
- Tick counter width is $clog2(CYCLES_PER_SEC). Decrement and compare are unsigned. Saturate at 0, never wrap.

## Configuration
- `AUTO_MOVE_EN` defined: timeout behaves as described above, with AUTO_SEEK/AUTO_DROP.
- `AUTO_MOVE_EN` undefined:
  - The AUTO states are removed.
  - On timeout the block enters WAIT_ACK with `times_up` held high and buttons blocked, until `state_in`≠1 or reset.
  - `auto_active` is tied to 0.

## Structure
- Shared package `connect4_pkg`:
  - the game state encoding `state_t`, with PLAYER_TURN=3'd1, shared with the game FSM;
  - NUM_COLS=7 and NUM_ROWS=6;
  - the scheduler state typedef;
  - the auto-pick column order constant.
- Sub-module `turn_timer`: tick and seconds counters with load, enable, `seconds_left` and timeout-pulse outputs.
- Target pick, button arbitration and the FSM stay in the top module.

## Test plan
Bench parameters: CYCLES_PER_SEC=4, TURN_SECONDS=3, STEP_GAP=2.
- Turn entry, `btn_drop` at cycle 5 with col_pos=2 and col 2 empty -> `move_made` at cycle 6, then WAIT_ACK. No `times_up`.
- `btn_drop` with `col_full`=7'b0000100 and col_pos=2 -> no `move_made`. `seconds_left` keeps counting 3,2,1.
- No input, col_pos=0, all columns empty:
  - `times_up` at cycle 12;
  - `move_right` at cycles 13, 15, 17;
  - `move_made` at 19 with col_pos=3.
- Timeout with col_pos=5 and `col_full`=7'b0001000 -> target 2, three `move_left` pulses, then `move_made`.
- Timeout with `col_full`=7'h7F -> `times_up` only, no moves, `seconds_left`=0. Then IDLE.
- Reset asserted mid-AUTO_SEEK -> next cycle all outputs 0, no further pulses. Same cycle `btn_left`+`btn_right` in HUMAN -> nothing forwarded.
